// File: rtl/fetch_sequencer_if.sv
// Handshake and strobe bundle between the fetch sequencer and the
// memory interface, register file and execute unit.
interface fetch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  run;
    logic [DATA_WIDTH-1:0] ir;
    logic                  mem_ack;
    logic                  exec_done;
    logic                  exec_halt;

    logic [2:0]            bus_sel;
    logic                  ar_we;
    logic                  pc_inc;
    logic                  ir_we;
    logic                  mem_req;
    logic [2:0]            opcode;
    logic                  i_flag;
    logic                  exec_start;
    logic                  halted;

    modport master (
        input  run, ir, mem_ack, exec_done, exec_halt,
        output bus_sel, ar_we, pc_inc, ir_we, mem_req,
               opcode, i_flag, exec_start, halted
    );

    modport slave (
        output run, ir, mem_ack, exec_done, exec_halt,
        input  bus_sel, ar_we, pc_inc, ir_we, mem_req,
               opcode, i_flag, exec_start, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Basic-computer instruction-cycle sequencer: fetch, decode and indirect
// resolution strobes for AR/PC/IR, then a start/done hand-off to execute.
module fetch_sequencer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int unsigned IFlagBit = 15;
    localparam int unsigned OpMsb    = 14;
    localparam int unsigned OpLsb    = 12;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_T0         = 3'd1;
    localparam logic [2:0] ST_T1         = 3'd2;
    localparam logic [2:0] ST_T2         = 3'd3;
    localparam logic [2:0] ST_T3         = 3'd4;
    localparam logic [2:0] ST_EXEC_START = 3'd5;
    localparam logic [2:0] ST_EXEC_WAIT  = 3'd6;
    localparam logic [2:0] ST_HALT       = 3'd7;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_MEM  = 3'd7;

    // D7 is register-reference / IO: its I bit never means indirect
    localparam logic [2:0] OP_D7 = 3'd7;

    if (DATA_WIDTH < 16 || ADDR_WIDTH > DATA_WIDTH - 4) begin : g_width_check
        $error("fetch_sequencer: need DATA_WIDTH >= 16 and ADDR_WIDTH <= DATA_WIDTH-4");
    end

    logic [2:0] state_q,      state_d;
    logic [2:0] bus_sel_q,    bus_sel_d;
    logic       ar_we_q,      ar_we_d;
    logic       mem_req_q,    mem_req_d;
    logic       exec_start_q, exec_start_d;
    logic       halted_q,     halted_d;
    logic [2:0] opcode_q,     opcode_d;
    logic       i_flag_q,     i_flag_d;

    logic       fetch_ack;
    logic       indirect_ack;
    logic       unused_ir_bits;

    // State and Moore strobes; Moore strobes are decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bus_sel_q    <= SEL_NONE;
            ar_we_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            exec_start_q <= 1'b0;
            halted_q     <= 1'b0;
            opcode_q     <= 3'd0;
            i_flag_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_sel_q    <= bus_sel_d;
            ar_we_q      <= ar_we_d;
            mem_req_q    <= mem_req_d;
            exec_start_q <= exec_start_d;
            halted_q     <= halted_d;
            opcode_q     <= opcode_d;
            i_flag_q     <= i_flag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        i_flag_d     = i_flag_q;
        bus_sel_d    = SEL_NONE;
        ar_we_d      = 1'b0;
        mem_req_d    = 1'b0;
        exec_start_d = 1'b0;
        halted_d     = 1'b0;

        case (state_q)
            ST_IDLE:       if (bus.run) state_d = ST_T0;
            ST_T0:         state_d = ST_T1;
            ST_T1:         if (bus.mem_ack) state_d = ST_T2;
            ST_T2: begin
                opcode_d = bus.ir[OpMsb:OpLsb];
                i_flag_d = bus.ir[IFlagBit];
                if (bus.ir[IFlagBit] && (bus.ir[OpMsb:OpLsb] != OP_D7)) begin
                    state_d = ST_T3;
                end else begin
                    state_d = ST_EXEC_START;
                end
            end
            ST_T3:         if (bus.mem_ack) state_d = ST_EXEC_START;
            ST_EXEC_START: state_d = ST_EXEC_WAIT;
            ST_EXEC_WAIT: begin
                if (bus.exec_done) begin
                    if (bus.exec_halt)  state_d = ST_HALT;
                    else if (bus.run)   state_d = ST_T0;
                    else                state_d = ST_IDLE;
                end
            end
            ST_HALT:       state_d = ST_HALT;
            default:       state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_T0: begin
                bus_sel_d = SEL_PC;
                ar_we_d   = 1'b1;
            end
            ST_T1, ST_T3: begin
                bus_sel_d = SEL_MEM;
                mem_req_d = 1'b1;
            end
            ST_T2: begin
                bus_sel_d = SEL_IR;
                ar_we_d   = 1'b1;
            end
            ST_EXEC_START: exec_start_d = 1'b1;
            ST_HALT:       halted_d     = 1'b1;
            default:       bus_sel_d    = SEL_NONE;
        endcase
    end

    // Memory-data strobes follow mem_ack in the same cycle
    assign fetch_ack    = (state_q == ST_T1) && bus.mem_ack;
    assign indirect_ack = (state_q == ST_T3) && bus.mem_ack;

    assign bus.bus_sel    = bus_sel_q;
    assign bus.ar_we      = ar_we_q | indirect_ack;
    assign bus.ir_we      = fetch_ack;
    assign bus.pc_inc     = fetch_ack;
    assign bus.mem_req    = mem_req_q;
    assign bus.opcode     = opcode_q;
    assign bus.i_flag     = i_flag_q;
    assign bus.exec_start = exec_start_q;
    assign bus.halted     = halted_q;

    assign unused_ir_bits = ^{bus.ir[OpLsb-1:0], bus.ir[DATA_WIDTH-1:IFlagBit]};
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with hand sequences
// for halt, reset-from-halt and asynchronous reset during T3.
module tb_fetch_sequencer;
    // Expected strobes {bus_sel[2:0], ar_we, pc_inc, ir_we, mem_req, exec_start, halted}
    localparam logic [8:0] O_ZERO = {3'd0, 6'b000000};
    localparam logic [8:0] O_T0   = {3'd2, 6'b100000};
    localparam logic [8:0] O_T1W  = {3'd7, 6'b000100};
    localparam logic [8:0] O_T1A  = {3'd7, 6'b011100};
    localparam logic [8:0] O_T2   = {3'd5, 6'b100000};
    localparam logic [8:0] O_T3W  = {3'd7, 6'b000100};
    localparam logic [8:0] O_T3A  = {3'd7, 6'b100100};
    localparam logic [8:0] O_XS   = {3'd0, 6'b000010};
    localparam logic [8:0] O_HLT  = {3'd0, 6'b000001};

    // ctl = {mem_ack, exec_done, exec_halt}
    typedef struct {
        logic        run;
        logic [15:0] ir;
        logic [2:0]  ctl;
        logic [8:0]  outs;
        logic [2:0]  opc;
        logic        ifl;
    } vec_t;

    vec_t vecs[$];
    int   checks    = 0;
    int   errors    = 0;
    int   pc_pulses = 0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_sequencer_if #(.DATA_WIDTH(16)) bus ();

    fetch_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic run, input logic [15:0] ir, input logic [2:0] ctl,
                       input logic [8:0] outs, input logic [2:0] opc, input logic ifl);
        vec_t v;
        v.run  = run;
        v.ir   = ir;
        v.ctl  = ctl;
        v.outs = outs;
        v.opc  = opc;
        v.ifl  = ifl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic run, input logic [15:0] ir, input logic [2:0] ctl);
        bus.run       = run;
        bus.ir        = ir;
        bus.mem_ack   = ctl[2];
        bus.exec_done = ctl[1];
        bus.exec_halt = ctl[0];
    endtask

    function automatic logic [8:0] outs_now();
        return {bus.bus_sel, bus.ar_we, bus.pc_inc, bus.ir_we, bus.mem_req,
                bus.exec_start, bus.halted};
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int idx, input logic [8:0] exp);
        check(name, idx, 16'(outs_now()), 16'(exp));
    endtask

    initial begin
        // Direct: 0x2123 has I=0 and ir[14:12]=2
        add(1'b0, 16'h0000, 3'b000, O_ZERO, 3'd0, 1'b0);
        add(1'b1, 16'h0000, 3'b000, O_ZERO, 3'd0, 1'b0);
        add(1'b1, 16'h2123, 3'b100, O_T0,   3'd0, 1'b0);
        add(1'b1, 16'h2123, 3'b100, O_T1A,  3'd0, 1'b0);
        add(1'b1, 16'h2123, 3'b100, O_T2,   3'd0, 1'b0);
        add(1'b1, 16'h2123, 3'b100, O_XS,   3'd2, 1'b0);
        add(1'b1, 16'h2123, 3'b110, O_ZERO, 3'd2, 1'b0);
        // Indirect 0xA045, done during EXEC_START ignored, halt without done ignored
        add(1'b1, 16'hA045, 3'b100, O_T0,   3'd2, 1'b0);
        add(1'b1, 16'hA045, 3'b100, O_T1A,  3'd2, 1'b0);
        add(1'b1, 16'hA045, 3'b100, O_T2,   3'd2, 1'b0);
        add(1'b1, 16'hA045, 3'b000, O_T3W,  3'd2, 1'b1);
        add(1'b1, 16'hA045, 3'b100, O_T3A,  3'd2, 1'b1);
        add(1'b1, 16'hA045, 3'b110, O_XS,   3'd2, 1'b1);
        add(1'b1, 16'hA045, 3'b001, O_ZERO, 3'd2, 1'b1);
        add(1'b1, 16'hA045, 3'b010, O_ZERO, 3'd2, 1'b1);
        // D7 with I=1 skips T3
        add(1'b1, 16'hF800, 3'b100, O_T0,   3'd2, 1'b1);
        add(1'b1, 16'hF800, 3'b100, O_T1A,  3'd2, 1'b1);
        add(1'b1, 16'hF800, 3'b100, O_T2,   3'd2, 1'b1);
        add(1'b1, 16'hF800, 3'b100, O_XS,   3'd7, 1'b1);
        add(1'b1, 16'hF800, 3'b110, O_ZERO, 3'd7, 1'b1);
        // Three wait cycles in T1
        add(1'b1, 16'h3000, 3'b000, O_T0,   3'd7, 1'b1);
        add(1'b1, 16'h3000, 3'b000, O_T1W,  3'd7, 1'b1);
        add(1'b1, 16'h3000, 3'b000, O_T1W,  3'd7, 1'b1);
        add(1'b1, 16'h3000, 3'b000, O_T1W,  3'd7, 1'b1);
        add(1'b1, 16'h3000, 3'b100, O_T1A,  3'd7, 1'b1);
        add(1'b1, 16'h3000, 3'b000, O_T2,   3'd7, 1'b1);
        add(1'b1, 16'h3000, 3'b000, O_XS,   3'd3, 1'b0);
        add(1'b1, 16'h3000, 3'b000, O_ZERO, 3'd3, 1'b0);
        add(1'b1, 16'h3000, 3'b010, O_ZERO, 3'd3, 1'b0);
        // run drops in T1: instruction completes, then IDLE
        add(1'b1, 16'h4000, 3'b000, O_T0,   3'd3, 1'b0);
        add(1'b0, 16'h4000, 3'b000, O_T1W,  3'd3, 1'b0);
        add(1'b0, 16'h4000, 3'b100, O_T1A,  3'd3, 1'b0);
        add(1'b0, 16'h4000, 3'b000, O_T2,   3'd3, 1'b0);
        add(1'b0, 16'h4000, 3'b000, O_XS,   3'd4, 1'b0);
        add(1'b0, 16'h4000, 3'b010, O_ZERO, 3'd4, 1'b0);
        add(1'b0, 16'h4000, 3'b100, O_ZERO, 3'd4, 1'b0);
        add(1'b0, 16'h4000, 3'b100, O_ZERO, 3'd4, 1'b0);
        // HLT instruction
        add(1'b1, 16'h7001, 3'b000, O_ZERO, 3'd4, 1'b0);
        add(1'b1, 16'h7001, 3'b100, O_T0,   3'd4, 1'b0);
        add(1'b1, 16'h7001, 3'b100, O_T1A,  3'd4, 1'b0);
        add(1'b1, 16'h7001, 3'b100, O_T2,   3'd4, 1'b0);
        add(1'b1, 16'h7001, 3'b100, O_XS,   3'd7, 1'b0);
        add(1'b1, 16'h7001, 3'b011, O_ZERO, 3'd7, 1'b0);
        add(1'b1, 16'h7001, 3'b111, O_HLT,  3'd7, 1'b0);

        drive(1'b1, 16'hFFFF, 3'b111);
        #2;
        check_outs("reset_outs", 0, O_ZERO);
        check("reset_opcode", 0, 16'(bus.opcode), 16'd0);
        check("reset_iflag", 0, 16'(bus.i_flag), 16'd0);
        @(negedge clk);
        check_outs("reset_held", 0, O_ZERO);
        drive(1'b0, 16'h0000, 3'b000);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].run, vecs[i].ir, vecs[i].ctl);
            #1;
            check_outs("strobes", i, vecs[i].outs);
            check("opcode", i, 16'(bus.opcode), 16'(vecs[i].opc));
            check("i_flag", i, 16'(bus.i_flag), 16'(vecs[i].ifl));
            check("we_overlap", i, 16'(bus.ar_we & bus.ir_we), 16'd0);
            check("pcinc_pcsel", i, 16'(bus.pc_inc && (bus.bus_sel == 3'd2)), 16'd0);
            if (bus.pc_inc) pc_pulses++;
            @(negedge clk);
        end
        check("pc_inc_pulses", 0, 16'(pc_pulses), 16'd6);

        // HALT ignores run and every other input
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'(k), 3'($urandom_range(0, 7)));
            #1;
            check_outs("halt_hold", k, O_HLT);
            @(negedge clk);
        end

        reset = 1'b0;
        #1;
        check_outs("halt_reset", 0, O_ZERO);
        check("halt_reset_opcode", 0, 16'(bus.opcode), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'hA045, 3'b100);
        #1;
        check_outs("idle_after_halt", 0, O_ZERO);
        @(negedge clk); #1;
        check_outs("seq_t0", 0, O_T0);
        @(negedge clk); #1;
        check_outs("seq_t1", 0, O_T1A);
        @(negedge clk); #1;
        check_outs("seq_t2", 0, O_T2);
        @(negedge clk);
        drive(1'b1, 16'hA045, 3'b000);
        #1;
        check_outs("seq_t3_wait", 0, O_T3W);
        // Reset lands 1 ns before the next rising edge
        #3;
        reset = 1'b0;
        #0.5;
        check_outs("async_reset", 0, O_ZERO);
        check("async_reset_iflag", 0, 16'(bus.i_flag), 16'd0);
        @(negedge clk);
        check_outs("reset_low_edge", 0, O_ZERO);
        reset = 1'b1;
        drive(1'b0, 16'hA045, 3'b100);
        #1;
        check_outs("release_idle", 0, O_ZERO);
        @(negedge clk);
        drive(1'b1, 16'hA045, 3'b100);
        #1;
        check_outs("idle_run_sampled", 0, O_ZERO);
        @(negedge clk); #1;
        check_outs("idle_to_t0", 0, O_T0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
